// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - per-LED PWM fader with saturating ramp FSMs; LED_PWM_FADER_GAMMA_EN selects a squared duty curve
module led_pwm_fader #(
    parameter int NUM_LEDS  = 4,
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 16,
    parameter int RAMP_STEP = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] leds_in,
    output logic [NUM_LEDS-1:0] pwm_out,
    output logic [NUM_LEDS-1:0] busy,
    output logic                period_start
);

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam int                  SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   MAX_W     = {1'b0, MAX};

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t              state    [NUM_LEDS];
    logic [PWM_BITS-1:0] level    [NUM_LEDS];
    logic [PWM_BITS-1:0] level_up [NUM_LEDS];
    logic [PWM_BITS-1:0] level_dn [NUM_LEDS];
    logic [PWM_BITS-1:0] duty     [NUM_LEDS];
    logic [PWM_BITS:0]   up_sum   [NUM_LEDS];
    logic [PWM_BITS:0]   dn_diff  [NUM_LEDS];
`ifdef LED_PWM_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq [NUM_LEDS];
`endif

    logic [NUM_LEDS-1:0] leds_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SW-1:0]       step_cnt;
    logic                wrap;
    logic                ramp_tick;

    // A wrap only happens while running, so ticks never fire when frozen
    assign wrap      = enable && (pwm_cnt == MAX);
    assign ramp_tick = wrap && (step_cnt == STEP_LAST);

    // Input sampling, PWM period counter and ramp prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q       <= '0;
            pwm_cnt      <= '0;
            step_cnt     <= '0;
            period_start <= 1'b0;
        end else begin
            leds_q       <= leds_in;
            period_start <= wrap;
            if (enable)
                pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap)
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

    // Saturating next levels (one extra bit catches overflow and borrow) and duty mapping
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            up_sum[i]   = {1'b0, level[i]} + STEP_W;
            dn_diff[i]  = {1'b0, level[i]} - STEP_W;
            level_up[i] = (up_sum[i] > MAX_W) ? MAX : up_sum[i][PWM_BITS-1:0];
            level_dn[i] = dn_diff[i][PWM_BITS] ? '0 : dn_diff[i][PWM_BITS-1:0];
`ifdef LED_PWM_FADER_GAMMA_EN
            level_sq[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
            duty[i]     = PWM_BITS'(level_sq[i] >> PWM_BITS);
`else
            duty[i]     = level[i];
`endif
        end
    end

    // Per-channel ramp FSM; a reversal takes priority over a tick in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                state[i] <= S_OFF;
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (state[i])
                    S_OFF: begin
                        if (leds_q[i]) begin
                            state[i] <= S_UP;
                            busy[i]  <= 1'b1;
                        end
                    end
                    S_UP: begin
                        if (!leds_q[i]) begin
                            state[i] <= S_DOWN;
                        end else if (level[i] == MAX) begin
                            state[i] <= S_ON;
                            busy[i]  <= 1'b0;
                        end else if (ramp_tick) begin
                            level[i] <= level_up[i];
                            if (level_up[i] == MAX) begin
                                state[i] <= S_ON;
                                busy[i]  <= 1'b0;
                            end
                        end
                    end
                    S_ON: begin
                        if (!leds_q[i]) begin
                            state[i] <= S_DOWN;
                            busy[i]  <= 1'b1;
                        end
                    end
                    S_DOWN: begin
                        if (leds_q[i]) begin
                            state[i] <= S_UP;
                        end else if (level[i] == '0) begin
                            state[i] <= S_OFF;
                            busy[i]  <= 1'b0;
                        end else if (ramp_tick) begin
                            level[i] <= level_dn[i];
                            if (level_dn[i] == '0) begin
                                state[i] <= S_OFF;
                                busy[i]  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state[i] <= S_OFF;
                        busy[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // PWM compare, one clock behind pwm_cnt; full level is solid on, frozen output is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++)
                pwm_out[i] <= enable && ((level[i] == MAX) || (pwm_cnt < duty[i]));
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed checks of led_pwm_fader at small and default parameters
`timescale 1ns/1ps
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       reset, enable, period_start;
    logic [3:0] leds_in, pwm_out, busy;
    logic       rst_def, en_def, ps_def;
    logic [3:0] leds_def, pwm_def, busy_def;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(.NUM_LEDS(4), .PWM_BITS(4), .STEP_DIV(2), .RAMP_STEP(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .leds_in(leds_in),
        .pwm_out(pwm_out), .busy(busy), .period_start(period_start)
    );

    led_pwm_fader dut_def (
        .clk(clk), .reset(rst_def), .enable(en_def), .leds_in(leds_def),
        .pwm_out(pwm_def), .busy(busy_def), .period_start(ps_def)
    );

    always @(posedge clk) begin
        if (rst_def) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic goto(input int k);
        if (cyc > k) check("goto_order", cyc, k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic measure(input int n, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int h0, h1, bad, pulses;
`ifdef LED_PWM_FADER_GAMMA_EN
    localparam int E4 = 1, E8 = 4, E12 = 9, E128 = 64;
`else
    localparam int E4 = 4, E8 = 8, E12 = 12, E128 = 128;
`endif

    initial begin
        reset = 1'b1; rst_def = 1'b1; enable = 1'b1; en_def = 1'b1;
        leds_in = 4'b1111; leds_def = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ps", period_start, 0);
        check("rst_def_busy", busy_def, 0);

        reset = 1'b0; rst_def = 1'b0;
        leds_in = 4'b0011; leds_def = 4'b0001;

        goto(1);  check("busy_lat1", busy, 0);
        goto(2);  check("busy_up", busy, 4'b0011);
        goto(15); check("ps_before", period_start, 0);
        goto(16); check("ps_pulse", period_start, 1);
        goto(17); check("ps_after", period_start, 0);

        goto(32); measure(16, h0, h1);
        check("lvl4_ch0", h0, E4);
        check("lvl4_ch1", h1, E4);
        goto(64); measure(16, h0, h1);
        check("lvl8_ch0", h0, E8);
        check("lvl8_ch1", h1, E8);

        leds_in = 4'b0001;
        goto(82); check("rev_busy", busy, 4'b0011);
        goto(96); measure(16, h0, h1);
        check("lvl12_ch0", h0, E12);
        check("dn4_ch1", h1, E4);

        goto(118);
        enable = 1'b0;
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (pwm_out != 4'b0000 || period_start) bad++;
        end
        check("freeze_outputs", bad, 0);
        check("freeze_busy", busy, 4'b0011);
        enable = 1'b1;

        goto(227); check("resume_busy_pre", busy, 4'b0011);
                   check("resume_ps_pre", period_start, 0);
        goto(228); check("resume_busy_tick", busy, 4'b0000);
                   check("resume_ps_tick", period_start, 1);
        measure(16, h0, h1);
        check("on_ch0", h0, 16);
        check("off_ch1", h1, 0);

        leds_in = 4'b0010;
        goto(250); check("preasync_busy", busy, 4'b0011);
        #2 reset = 1'b1;
        #1;
        check("async_pwm", pwm_out, 0);
        check("async_busy", busy, 0);
        check("async_ps", period_start, 0);

        goto(255); check("def_ps_before", ps_def, 0);
        goto(256); check("def_ps_pulse", ps_def, 1);
        goto(257); check("def_ps_after", ps_def, 0);
        pulses = 0;
        for (int j = 0; j < 1024; j++) begin
            @(negedge clk);
            pulses += int'(ps_def);
        end
        check("def_ps_count", pulses, 4);

        goto(32768);
        h0 = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            h0 += int'(pwm_def[0]);
        end
        check("def_lvl128", h0, E128);

        goto(65535); check("def_busy_pre", busy_def, 4'b0001);
        goto(65536); check("def_busy_on", busy_def, 4'b0000);
        h0 = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            h0 += int'(pwm_def[0]);
        end
        check("def_on", h0, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream stage of the LED pattern FSM.
- Consumes its on/off pattern bus (one bit per LED).
- Drives each physical LED with a PWM signal whose brightness ramps up and down smoothly instead of snapping.
- Sits between the FSM's `leds` output and the board pins.

Parameters:
- NUM_LEDS, 4: number of LED channels; width of the pattern and PWM buses.
- PWM_BITS, 8: PWM counter and brightness level width. MAX = 2^PWM_BITS-1.
- STEP_DIV, 16: number of complete PWM periods between ramp ticks. Must be ≥1.
- RAMP_STEP, 16: level change applied per ramp tick. Must be 1..MAX.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run/freeze control.
- leds_in  input  NUM_LEDS  on/off pattern from the LED FSM.
- pwm_out  output  NUM_LEDS  registered PWM drive per LED.
- busy  output  NUM_LEDS  per-channel flag: 1 while that channel is ramping.
- period_start  output  1  one-cycle pulse at the start of each PWM period.

Behaviour:
- Reset (asynchronous, active-high): all registers clear immediately, including mid-ramp.
  - pwm_cnt, step_cnt and all levels go to 0.
  - All channel states go to OFF.
  - leds_q, pwm_out, busy and period_start all go to 0.
- Input sampling: leds_in is registered into leds_q every clock. A change on leds_in alters the channel state 2 clocks later.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) increments each clock while enable=1, wrapping from MAX to 0.
  - period_start is registered: 1 for exactly the cycle after pwm_cnt==MAX and enable=1.
- Ramp tick:
  - step_cnt counts pwm_cnt wraps, from 0 to STEP_DIV-1.
  - ramp_tick is asserted on the wrap where step_cnt==STEP_DIV-1; step_cnt then returns to 0.
  - Ramp period = STEP_DIV·2^PWM_BITS clocks.
- Per-channel FSM (states OFF, UP, ON, DOWN):
  - State transitions are evaluated every clock. Level changes happen only on ramp_tick.
  - OFF (level 0): leds_q=1 → UP.
  - UP:
    - leds_q=0 → DOWN, with the current level kept.
    - Otherwise, on tick: level = min(level+RAMP_STEP, MAX).
    - level==MAX → ON.
  - ON (level MAX): leds_q=0 → DOWN.
  - DOWN:
    - leds_q=1 → UP, with the current level kept.
    - Otherwise, on tick: level = max(level-RAMP_STEP, 0).
    - level==0 → OFF.
  - Arithmetic is done at PWM_BITS+1 bits, then saturated. No wrap-around of level is permitted.
- busy[i] = 1 when channel i is in UP or DOWN (registered with the state).
- PWM output (registered, 1 clock after pwm_cnt):
  - pwm_out[i] = 1 if duty[i]==MAX (fully on).
  - pwm_out[i] = 0 if duty[i]==0.
  - Otherwise pwm_out[i] = (pwm_cnt < duty[i]).
  - Without the optional feature, duty = level.
- enable=0:
  - pwm_cnt, step_cnt and levels freeze.
  - pwm_out is forced to 0 and period_start to 0.
  - leds_q sampling and the state transitions that do not need a tick still occur.
  - Resuming enable continues from the frozen counts.
- Simultaneous events:
  - A tick and a leds_q reversal in the same cycle: the reversal wins. The state changes and the level is not stepped that cycle.
  - A tick that reaches MAX or 0 moves the state to ON or OFF on that same clock edge.

Optional Feature:
- Macro LED_PWM_FADER_GAMMA_EN.
- When defined: duty = (level·level) >> PWM_BITS, for a perceptual gamma≈2 curve.
  - Computed at 2·PWM_BITS bits.
  - level==MAX still forces fully on; level==0 is fully off.
- When undefined: duty = level (linear), and no multiplier is instantiated.

Test Plan:
Tests 1–4 run with PWM_BITS=4, STEP_DIV=2, RAMP_STEP=4, so MAX=15 and a tick occurs every 32 clocks.
1. Reset check: hold reset=1 for 2 clocks with leds_in=4'b1111 → pwm_out=0, busy=0, period_start=0. Assert reset asynchronously mid-ramp → all outputs 0 within the same cycle.
2. Ramp up: enable=1, leds_in=4'b0001 → busy[0]=1; level steps 4, 8, 12, 15 on successive ticks; state ON after the 4th tick with busy[0]=0 and pwm_out[0] constantly 1. At level 8, pwm_out[0] is high for 8 of every 16 clocks.
3. Reversal: leds_in[1] goes 1, then drops to 0 after the 2nd tick (level 8) → DOWN; level steps 4, 0; then OFF with pwm_out[1] constantly 0 and no underflow.
4. Freeze: deassert enable at level 12 for 100 clocks → pwm_out=0 and period_start=0 throughout. After re-enable, pwm_cnt resumes from its frozen value and the next tick arrives after the remaining clocks of the step period.
5. Period pulse, default parameters: period_start pulses exactly once every 256 clocks. A ramp from 0 to 255 takes 16 ticks, i.e. 65536 clocks.
6. Gamma, with LED_PWM_FADER_GAMMA_EN and PWM_BITS=4: level 8 → 4 high clocks per 16; level 15 → always high. Without the macro, level 8 → 8 high clocks per 16.
